// File: rtl/dsram_arbiter.sv
// dsram_arbiter
//
// Arbitrates the single data-SRAM port between instruction fetch (IF, read
// only) and the load/store path (LS). One transaction is in flight at a time:
// the winning request's payload is latched, driven on the memory port until
// mem_ack or timeout, and the response is returned to the owner as a
// registered one-cycle rvalid pulse.
//
// LS normally wins a simultaneous request. A streak counter tracks LS wins
// while IF is waiting. Once it reaches STARVE_LIMIT, the next contended
// grant goes to IF.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   if_req/if_addr  IF read request and address (held until if_gnt)
//   if_gnt          combinational grant to IF (IDLE only)
//   if_rvalid/if_rdata  registered response to IF
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wstrb  LS request and payload
//   ls_gnt          combinational grant to LS (IDLE only)
//   ls_rvalid/ls_rdata  registered completion to LS (rdata 0 for stores)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  registered memory request
//   mem_ack/mem_rdata  memory completion and read data
//   bus_err         registered one-cycle pulse on timeout abort

module dsram_arbiter #(
    parameter int AW           = 64,
    parameter int DW           = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,

    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_wstrb,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,

    output logic            bus_err
);

    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    // The counter holds the number of completed busy cycles. Expiry is
    // therefore the TIMEOUT-th busy cycle, when the count equals TIMEOUT-1.
    localparam logic [7:0]    WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t        state_reg;
    logic [SW-1:0] streak_reg;
    logic [7:0]    wait_cnt_reg;

    // Grants are combinational so the requester sees its grant in the same
    // cycle it asserts req. They are forced low during reset.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rst && state_reg == IDLE) begin
            if (if_req && (!ls_req || streak_reg == STREAK_MAX)) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            streak_reg   <= '0;
            wait_cnt_reg <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            ls_rvalid    <= 1'b0;
            ls_rdata     <= '0;
            bus_err      <= 1'b0;
        end else begin
            // Response strobes are single-cycle pulses by default.
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            bus_err   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (if_gnt) begin
                        state_reg    <= BUSY_IF;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        mem_wdata    <= '0;
                        mem_wstrb    <= '0;
                        wait_cnt_reg <= '0;
                        streak_reg   <= '0;
                    end else if (ls_gnt) begin
                        state_reg    <= BUSY_LS;
                        mem_req      <= 1'b1;
                        mem_we       <= ls_we;
                        mem_addr     <= ls_addr;
                        mem_wdata    <= ls_wdata;
                        mem_wstrb    <= ls_wstrb;
                        wait_cnt_reg <= '0;
                        // Only LS wins that leave IF waiting count toward
                        // starvation. An uncontended LS grant restarts it.
                        if (!if_req) begin
                            streak_reg <= '0;
                        end else if (streak_reg != STREAK_MAX) begin
                            streak_reg <= streak_reg + 1'b1;
                        end
                    end
                end

                BUSY_IF, BUSY_LS: begin
                    // An ack in the expiry cycle wins over the timeout.
                    if (mem_ack) begin
                        state_reg <= IDLE;
                        mem_req   <= 1'b0;
                        if (state_reg == BUSY_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end else begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= mem_we ? '0 : mem_rdata;
                        end
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= IDLE;
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        if (state_reg == BUSY_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end else begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= '0;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsram_arbiter.sv
// Testbench for dsram_arbiter.
//
// A table of single transactions runs first. Each entry gives the stimulus
// and the hand-computed results: memory payload, owner rdata, and bus_err.
// Hand-written sequences then cover the following cases:
//   - reset values
//   - a spurious ack in IDLE
//   - LS/IF contention with starvation relief
//   - reset in the middle of a transaction
// The bench is built with TIMEOUT=8.

module tb_dsram_arbiter;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int SL  = 4;
    localparam int TMO = 8;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [7:0]    ls_wstrb;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    mem_wstrb;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          bus_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_if_hold;
    logic [63:0] exp_ls_hold;

    dsram_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ack_k: the busy cycle (1 = first cycle mem_req is high) in which
    // mem_ack is driven. A value of 0 means no ack, so the transaction
    // times out.
    typedef struct {
        logic        is_ls;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          ack_k;
        logic [63:0] mrdata;
        logic        exp_we;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int limit;
        // Grant cycle N. The ls_* payload is driven even for IF entries so
        // the IF path can be seen to latch zero write data and strobes.
        if_addr  = v.addr;
        ls_addr  = v.addr;
        ls_we    = v.we;
        ls_wdata = v.wdata;
        ls_wstrb = v.wstrb;
        if_req   = !v.is_ls;
        ls_req   = v.is_ls;
        #1;
        check("if_gnt", {63'd0, if_gnt}, {63'd0, !v.is_ls});
        check("ls_gnt", {63'd0, ls_gnt}, {63'd0, v.is_ls});
        tick();
        if_req = 1'b0;
        ls_req = 1'b0;
        #1;
        check("mem_req_rise", {63'd0, mem_req}, 64'd1);
        check("mem_we",    {63'd0, mem_we}, {63'd0, v.exp_we});
        check("mem_addr",  mem_addr, v.addr);
        check("mem_wdata", mem_wdata, v.exp_wdata);
        check("mem_wstrb", {56'd0, mem_wstrb}, {56'd0, v.exp_wstrb});
        limit = (v.ack_k == 0) ? TMO : v.ack_k;
        for (int k = 1; k <= limit; k++) begin
            if (k > 1) begin
                tick();
                check("mem_req_busy", {63'd0, mem_req}, 64'd1);
            end
            if (k == v.ack_k) begin
                mem_ack   = 1'b1;
                mem_rdata = v.mrdata;
            end
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        check("mem_req_done", {63'd0, mem_req}, 64'd0);
        check("if_rvalid", {63'd0, if_rvalid}, {63'd0, !v.is_ls});
        check("ls_rvalid", {63'd0, ls_rvalid}, {63'd0, v.is_ls});
        check("bus_err", {63'd0, bus_err}, {63'd0, v.exp_err});
        if (v.is_ls) exp_ls_hold = v.exp_rdata;
        else         exp_if_hold = v.exp_rdata;
        check("if_rdata", if_rdata, exp_if_hold);
        check("ls_rdata", ls_rdata, exp_ls_hold);
        tick();
        check("rvalid_pulse_end", {61'd0, if_rvalid, ls_rvalid, bus_err}, 64'd0);
        $display("txn %0d: %s addr=%h ack_k=%0d if_rdata=%h ls_rdata=%h bus_err_seen=%0d",
                 idx, v.is_ls ? "LS" : "IF", v.addr, v.ack_k, if_rdata, ls_rdata, v.exp_err);
    endtask

    vec_t extra;
    logic exp_ls_win;

    initial begin
        // Table fields, in order:
        //   is_ls, we, addr, wdata, wstrb, ack_k, mem_rdata,
        //   exp_we, exp_wdata, exp_wstrb, exp_rdata, exp_err
        vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_0000_FFFF_0000, 8'hF0, 4,
                    64'h1122334455667788, 1'b0, 64'd0, 8'h00, 64'h1122334455667788, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 64'h100, 64'hAB, 8'h01, 1,
                    64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'hAB, 8'h01, 64'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 64'h200, 64'h0, 8'h00, 2,
                    64'hCAFEF00D12345678, 1'b0, 64'h0, 8'h00, 64'hCAFEF00D12345678, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 64'h300, 64'h0, 8'h00, 0,
                    64'h0, 1'b0, 64'h0, 8'h00, 64'd0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 64'h0000_0000_8000_0040, 64'h1234, 8'hFF, TMO,
                    64'h0123456789ABCDEF, 1'b0, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 64'h0000_0000_8000_0080, 64'h0, 8'h00, 0,
                    64'h0, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 64'h8, 64'h5555_5555_5555_5555, 8'hFF, TMO,
                    64'h9999_8888_7777_6666, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, 64'd0, 1'b0};

        rst = 1'b1;
        if_req = 1'b1;
        ls_req = 1'b1;
        if_addr = '0;
        ls_we = 1'b0;
        ls_addr = '0;
        ls_wdata = '0;
        ls_wstrb = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        exp_if_hold = '0;
        exp_ls_hold = '0;

        // Reset: grants stay low while rst is high, and the registered
        // outputs clear.
        tick();
        tick();
        check("rst_if_gnt", {63'd0, if_gnt}, 64'd0);
        check("rst_ls_gnt", {63'd0, ls_gnt}, 64'd0);
        check("rst_strobes", {60'd0, mem_req, if_rvalid, ls_rvalid, bus_err}, 64'd0);
        check("rst_mem_payload", {63'd0, mem_we} | mem_addr | mem_wdata | {56'd0, mem_wstrb}, 64'd0);
        check("rst_rdata", if_rdata | ls_rdata, 64'd0);
        if_req = 1'b0;
        ls_req = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i], i);
        end

        // A spurious ack in IDLE must produce no response and no state change.
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("spur_gnt", {62'd0, if_gnt, ls_gnt}, 64'd0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        check("spur_strobes", {60'd0, mem_req, if_rvalid, ls_rvalid, bus_err}, 64'd0);
        check("spur_if_rdata", if_rdata, exp_if_hold);
        check("spur_ls_rdata", ls_rdata, exp_ls_hold);
        tick();
        check("spur_still_idle", {63'd0, mem_req}, 64'd0);
        $display("txn spurious_ack: no response observed=%0d", !(if_rvalid | ls_rvalid));

        // Contention: both requesters held high, ack in the first busy cycle.
        // Every fifth grant must go to IF, and a new grant must come in the
        // same cycle as the previous rvalid.
        if_addr = 64'h0000_0000_8000_0400;
        ls_addr = 64'h400;
        ls_we   = 1'b0;
        if_req  = 1'b1;
        ls_req  = 1'b1;
        for (int g = 0; g < 10; g++) begin
            #1;
            exp_ls_win = ((g % 5) != 4);
            check("cont_if_gnt", {63'd0, if_gnt}, {63'd0, !exp_ls_win});
            check("cont_ls_gnt", {63'd0, ls_gnt}, {63'd0, exp_ls_win});
            $display("txn contention grant %0d: if_gnt=%0d ls_gnt=%0d expected %s",
                     g, if_gnt, ls_gnt, exp_ls_win ? "LS" : "IF");
            tick();
            if (g == 9) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            #1;
            check("cont_mem_req", {63'd0, mem_req}, 64'd1);
            if (g != 9) check("cont_busy_no_gnt", {62'd0, if_gnt, ls_gnt}, 64'd0);
            check("cont_mem_addr", mem_addr, exp_ls_win ? 64'h400 : 64'h0000_0000_8000_0400);
            mem_ack   = 1'b1;
            mem_rdata = 64'h100 + 64'(g);
            tick();
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (exp_ls_win) exp_ls_hold = 64'h100 + 64'(g);
            else            exp_if_hold = 64'h100 + 64'(g);
            check("cont_if_rvalid", {63'd0, if_rvalid}, {63'd0, !exp_ls_win});
            check("cont_ls_rvalid", {63'd0, ls_rvalid}, {63'd0, exp_ls_win});
            check("cont_if_rdata", if_rdata, exp_if_hold);
            check("cont_ls_rdata", ls_rdata, exp_ls_hold);
        end
        tick();

        // Reset during BUSY_IF: the request is dropped and a late ack is
        // ignored.
        if_addr = 64'h0000_0000_8000_1000;
        if_req  = 1'b1;
        #1;
        check("rstmid_if_gnt", {63'd0, if_gnt}, 64'd1);
        tick();
        if_req = 1'b0;
        #1;
        check("rstmid_busy", {63'd0, mem_req}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_mem_req", {63'd0, mem_req}, 64'd0);
        check("rstmid_rvalid", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
        check("rstmid_rdata", if_rdata | ls_rdata, 64'd0);
        exp_if_hold = '0;
        exp_ls_hold = '0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        check("late_ack_ignored", {60'd0, mem_req, if_rvalid, ls_rvalid, bus_err}, 64'd0);
        check("late_ack_rdata", if_rdata, 64'd0);
        $display("txn reset_mid_busy: mem_req=%0d if_rvalid=%0d after late ack", mem_req, if_rvalid);
        extra = '{1'b0, 1'b0, 64'h0000_0000_8000_2000, 64'h0, 8'h00, 1,
                  64'h7777_6666_5555_4444, 1'b0, 64'd0, 8'h00, 64'h7777_6666_5555_4444, 1'b0};
        do_txn(extra, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
